// File: rtl/alu_definitions.sv
// Shared ALU definitions: opcode encoding, response-slot states and sizing limits.
package alu_definitions;

  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOR = 3'd5,
    OP_SLT = 3'd6,
    OP_SLL = 3'd7
  } alu_op_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // ptr is always below NUM_REQ, so one conditional subtract implements the wrap.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between NUM_REQ
// requesters, with a single registered, tagged response slot.
import alu_definitions::*;

module alu_rr_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*3-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [2:0]                alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2:0]                rsp_op,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [CNT_W-1:0]          ops_issued
);

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic                can_accept;
  logic                transfer;
  logic [ID_W-1:0]     next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The slot can take a new result when empty or when it is drained this same cycle.
  assign can_accept = (state == RSP_EMPTY) || rsp_ready;
  assign req_ready  = can_accept ? grant : '0;
  assign transfer   = grant_valid && can_accept;
  assign next_ptr   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (grant_valid) begin
      alu_op = req_op[int'(grant_idx)*3 +: 3];
      alu_a  = req_a[int'(grant_idx)*DATA_W +: DATA_W];
      alu_b  = req_b[int'(grant_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RSP_EMPTY;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_op     <= OP_ADD;
      rsp_data   <= '0;
      rr_ptr     <= '0;
      ops_issued <= '0;
    end else begin
      if (transfer) begin
        rsp_data   <= alu_result;
        rsp_id     <= grant_idx;
        rsp_op     <= alu_op;
        rr_ptr     <= next_ptr;
        ops_issued <= ops_issued + 1'b1;
      end
      case (state)
        RSP_EMPTY: begin
          if (transfer) begin
            state     <= RSP_FULL;
            rsp_valid <= 1'b1;
          end
        end
        RSP_FULL: begin
          if (rsp_ready && !transfer) begin
            state     <= RSP_EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= RSP_EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
